// File: rtl/tx_p2s.sv
// Parallel-to-serial transmitter: a holding register feeds a shift register that
// streams bytes LSB first on TDO, back to back, with halt, abort and status pulses.
module tx_p2s #(
    parameter int   DATA_W   = 8,
    parameter logic IDLE_LVL = 1'b1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              TCS,
    input  logic              halt_tx,
    input  logic              TX_LOAD,
    input  logic [DATA_W-1:0] DATA,
    input  logic              TX_LAST_BYTE,
    output logic              TDO,
    output logic              TX_READY_LD,
    output logic              TX_BUSY,
    output logic              TX_DONE,
    output logic              TX_UNDERRUN,
    output logic              TX_OVF
);

    localparam int CW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(DATA_W - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t            r_state;
    logic [DATA_W-1:0] r_hr;
    logic              r_hr_v;
    logic              r_hr_last;
    logic [DATA_W-1:0] r_sr;
    logic [CW-1:0]     r_cnt;
    logic              r_sr_last;
    logic              r_last_pending;
    logic              r_tdo;
    logic              r_busy;
    logic              r_done;
    logic              r_underrun;
    logic              r_ovf;

    state_t            w_state_nxt;
    logic [DATA_W-1:0] w_hr_nxt;
    logic              w_hr_v_nxt;
    logic              w_hr_last_nxt;
    logic [DATA_W-1:0] w_sr_nxt;
    logic [CW-1:0]     w_cnt_nxt;
    logic              w_sr_last_nxt;
    logic              w_lp_nxt;
    logic              w_tdo_nxt;
    logic              w_done_nxt;
    logic              w_under_nxt;
    logic              w_xfer;
    logic              w_ready;
    logic              w_accept;
    logic [CW-1:0]     w_cnt_inc;

    assign w_ready   = TCS & ~r_hr_v & ~r_last_pending;
    assign w_accept  = TX_LOAD & w_ready;
    assign w_cnt_inc = r_cnt + CW'(1);

    // Next-state and next-datapath decode
    always_comb begin
        w_state_nxt   = r_state;
        w_hr_nxt      = r_hr;
        w_hr_v_nxt    = r_hr_v;
        w_hr_last_nxt = r_hr_last;
        w_sr_nxt      = r_sr;
        w_cnt_nxt     = r_cnt;
        w_sr_last_nxt = r_sr_last;
        w_lp_nxt      = r_last_pending;
        w_tdo_nxt     = r_tdo;
        w_done_nxt    = 1'b0;
        w_under_nxt   = 1'b0;
        w_xfer        = 1'b0;

        if (!TCS) begin
            // Abort wins over everything, including halt_tx.
            w_state_nxt = ST_IDLE;
            w_hr_v_nxt  = 1'b0;
            w_lp_nxt    = 1'b0;
            w_cnt_nxt   = {CW{1'b0}};
            w_tdo_nxt   = IDLE_LVL;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_tdo_nxt = IDLE_LVL;
                    if (r_hr_v && !halt_tx) begin
                        w_xfer = 1'b1;
                    end else begin
                        w_xfer = 1'b0;
                    end
                end
                ST_SHIFT: begin
                    if (halt_tx) begin
                        w_state_nxt = ST_SHIFT;
                    end else if (r_cnt != LAST_BIT) begin
                        w_tdo_nxt = r_sr[w_cnt_inc];
                        w_cnt_nxt = w_cnt_inc;
                    end else if (r_hr_v) begin
                        w_xfer = 1'b1;
                    end else if (r_sr_last) begin
                        w_state_nxt = ST_DONE;
                        w_tdo_nxt   = IDLE_LVL;
                        w_done_nxt  = 1'b1;
                        w_lp_nxt    = 1'b0;
                    end else begin
                        w_state_nxt = ST_IDLE;
                        w_tdo_nxt   = IDLE_LVL;
                        w_under_nxt = 1'b1;
                    end
                end
                ST_DONE: begin
                    w_state_nxt = ST_IDLE;
                    w_tdo_nxt   = IDLE_LVL;
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                    w_tdo_nxt   = IDLE_LVL;
                end
            endcase

            if (w_xfer) begin
                w_state_nxt   = ST_SHIFT;
                w_sr_nxt      = r_hr;
                w_sr_last_nxt = r_hr_last;
                w_hr_v_nxt    = 1'b0;
                w_cnt_nxt     = {CW{1'b0}};
                w_tdo_nxt     = r_hr[0];
            end else begin
                w_sr_nxt = w_sr_nxt;
            end

            // A transfer needs hr_v=1, which already blocks acceptance, so these never collide.
            if (w_accept) begin
                w_hr_nxt      = DATA;
                w_hr_last_nxt = TX_LAST_BYTE;
                w_hr_v_nxt    = 1'b1;
                w_lp_nxt      = w_lp_nxt | TX_LAST_BYTE;
            end else begin
                w_hr_nxt = w_hr_nxt;
            end
        end
    end

    // State, datapath and registered status outputs
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state        <= ST_IDLE;
            r_hr           <= {DATA_W{1'b0}};
            r_hr_v         <= 1'b0;
            r_hr_last      <= 1'b0;
            r_sr           <= {DATA_W{1'b0}};
            r_cnt          <= {CW{1'b0}};
            r_sr_last      <= 1'b0;
            r_last_pending <= 1'b0;
            r_tdo          <= IDLE_LVL;
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
            r_underrun     <= 1'b0;
            r_ovf          <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_hr           <= w_hr_nxt;
            r_hr_v         <= w_hr_v_nxt;
            r_hr_last      <= w_hr_last_nxt;
            r_sr           <= w_sr_nxt;
            r_cnt          <= w_cnt_nxt;
            r_sr_last      <= w_sr_last_nxt;
            r_last_pending <= w_lp_nxt;
            r_tdo          <= w_tdo_nxt;
            r_busy         <= (w_state_nxt == ST_SHIFT);
            r_done         <= w_done_nxt;
            r_underrun     <= w_under_nxt;
            r_ovf          <= TX_LOAD & ~w_ready;
        end
    end

    assign TDO         = r_tdo;
    assign TX_READY_LD = w_ready;
    assign TX_BUSY     = r_busy;
    assign TX_DONE     = r_done;
    assign TX_UNDERRUN = r_underrun;
    assign TX_OVF      = r_ovf;

endmodule

// File: doc/tx_p2s.md
TX_P2S -- requirements
Module: tx_p2s

Interface
REQ-001 Parameter: DATA_W, 8, byte width of parallel load and shift register.
REQ-002 Parameter: IDLE_LVL, 1'b1, TDO level when not shifting.
REQ-003 clock  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low; reset=0 forces the reset state immediately.
REQ-005 TCS  input  1  transmit chip select; 1 enables the transmitter, 0 aborts and idles it.
REQ-006 halt_tx  input  1  1 freezes shifting, bit counter and TDO for that cycle.
REQ-007 TX_LOAD  input  1  strobe; byte on DATA is offered on this edge.
REQ-008 DATA  input  DATA_W  parallel byte to transmit.
REQ-009 TX_LAST_BYTE  input  1  qualifies DATA as the final byte of the packet when TX_LOAD=1.
REQ-010 TDO  output  1  registered serial data out, LSB first.
REQ-011 TX_READY_LD  output  1  combinational; 1 = a TX_LOAD on this edge is accepted.
REQ-012 TX_BUSY  output  1  registered; 1 while in SHIFT.
REQ-013 TX_DONE  output  1  registered one-cycle pulse; last byte fully shifted.
REQ-014 TX_UNDERRUN  output  1  registered one-cycle pulse; byte ended, no next byte, not last.
REQ-015 TX_OVF  output  1  registered one-cycle pulse; TX_LOAD while TX_READY_LD=0.

Function
REQ-016 Two stages: holding register (HR, hr_v, hr_last) and shift register (SR, cnt 0..DATA_W-1, sr_last).
REQ-017 TX_READY_LD = TCS & ~hr_v & ~last_pending; last_pending sets when a last byte is accepted and clears on TX_DONE, abort or reset.
REQ-018 Edge with TX_LOAD=1 and TX_READY_LD=1: HR<=DATA, hr_last<=TX_LAST_BYTE, hr_v<=1.
REQ-019 Edge with TX_LOAD=1 and TX_READY_LD=0: HR unchanged, TX_OVF<=1 for one cycle.
REQ-020 FSM states IDLE, SHIFT, DONE; TDO=IDLE_LVL in IDLE and DONE.
REQ-021 IDLE->SHIFT on edge with TCS=1, hr_v=1, halt_tx=0: SR<=HR, sr_last<=hr_last, hr_v<=0, cnt<=0, TDO<=HR[0].
REQ-022 SHIFT, halt_tx=0, cnt<DATA_W-1: TDO<=SR[cnt+1], cnt<=cnt+1; each bit held exactly one unhalted cycle.
REQ-023 SHIFT, halt_tx=0, cnt=DATA_W-1, hr_v=1: reload per REQ-021 in same edge, zero-gap, stay SHIFT.
REQ-024 SHIFT, halt_tx=0, cnt=DATA_W-1, hr_v=0, sr_last=1: ->DONE, TDO<=IDLE_LVL, TX_DONE<=1.
REQ-025 SHIFT, halt_tx=0, cnt=DATA_W-1, hr_v=0, sr_last=0: ->IDLE, TDO<=IDLE_LVL, TX_UNDERRUN<=1.
REQ-026 DONE->IDLE unconditionally next edge; TX_DONE drops.
REQ-027 halt_tx=1 in SHIFT: SR, cnt, TDO, state frozen; HR loads still accepted.
REQ-028 TCS=0 on any edge in SHIFT/DONE: ->IDLE, hr_v<=0, last_pending<=0, TDO<=IDLE_LVL, no pulses; TCS=0 overrides halt_tx.
REQ-029 A load and an HR->SR transfer on the same edge: load is ignored, since TX_READY_LD was 0 (TX_OVF raised).

Reset
REQ-030 reset=0: state IDLE, TDO=IDLE_LVL, hr_v=0, last_pending=0, cnt=0, TX_BUSY=TX_DONE=TX_UNDERRUN=TX_OVF=0; TX_READY_LD then equals TCS.
REQ-031 Reset asserted mid-byte aborts the transfer; no pulse is produced after release.

Verification
REQ-032 TCS=1, load 0xA5 with TX_LAST_BYTE=1 -> TDO 1,0,1,0,0,1,0,1 on 8 consecutive cycles, then TDO=1 and TX_DONE=1 for one cycle.
REQ-033 Load 0x3C (last=0), then 0xFF (last=1) during the first byte -> 16 contiguous bits 0,0,1,1,1,1,0,0,1x8, no idle gap, one TX_DONE.
REQ-034 Load 0x0F (last=1), halt_tx=1 for 3 cycles while bit 2 is on TDO -> bit 2 (=1) held 4 cycles, rest unchanged, TX_DONE 3 cycles later than REQ-032.
REQ-035 Load 0x81 (last=0), no further load -> 8 bits 1,0,0,0,0,0,0,1, then TX_UNDERRUN pulse, TDO=1, state IDLE.
REQ-036 Load 0x55, load 0xAA, load 0x11 before HR empties -> third load raises TX_OVF one cycle; 0x11 never appears on TDO.
REQ-037 TCS=0 (or reset=0) after 3 bits of 0xC3 -> TDO=1 next edge, TX_BUSY=0, no TX_DONE/UNDERRUN, TX_READY_LD=1 once TCS=1 again.
